// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, tag base, requester limit.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_TAG       = 3'd1,
    ST_ACCEPT    = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_BUSY = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;
  localparam int         N_REQ_MAX        = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating priority encoder: first set bit of i_req at or above i_ptr, wrapping; purely combinational.
module uart_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  logic [W-1:0] w_idx;

  // Walk from the farthest offset down so the nearest requester wins.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = W'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_idx   = w_idx;
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among N_REQ byte streams.
// Build option UART_ARB_TAG_EN prefixes each packet with a TAG_BASE|grant_id byte.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         N_REQ        = 4,
  parameter int         IDLE_TIMEOUT = 1000,
  parameter logic [7:0] TAG_BASE     = TAG_BASE_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  input  logic [N_REQ-1:0]         req_last,
  output logic [N_REQ-1:0]         req_ready,
  output logic [7:0]               uart_tx_data,
  output logic                     uart_tx_en,
  input  logic                     uart_tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     grant_active,
  output logic                     abort_pulse
);

  localparam int             GW      = $clog2(N_REQ);
  localparam int             CW      = $clog2(IDLE_TIMEOUT + 2);
  localparam logic [CW-1:0]  TO_LAST = CW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam logic [GW-1:0]  LAST_ID = GW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > N_REQ_MAX) begin : g_bad_n
    $error("uart_tx_arbiter: N_REQ out of range");
  end

  state_t        r_state, w_next;
  logic [GW-1:0] r_grant, r_rr, w_pick;
  logic          w_found, r_active, r_last;
  logic [7:0]    r_hold, r_tx_data;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_release, w_timeout;
  logic [7:0]    w_bytes [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[8*g +: 8];
  end

  uart_rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  assign w_timeout    = (IDLE_TIMEOUT != 0) && (r_cnt == TO_LAST);
  assign uart_tx_data = (r_state == ST_ISSUE) ? r_hold : r_tx_data;
  assign grant_id     = r_grant;
  assign grant_active = r_active;

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    uart_tx_en  = 1'b0;
    abort_pulse = 1'b0;
    w_accept    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
`ifdef UART_ARB_TAG_EN
          w_next = ST_TAG;
`else
          w_next = ST_ACCEPT;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_TAG: w_next = ST_ISSUE;
`endif
      ST_ACCEPT: begin
        req_ready[r_grant] = 1'b1;
        // A byte arriving on the timeout cycle is still taken.
        if (req_valid[r_grant]) begin
          w_accept = 1'b1;
          w_next   = ST_ISSUE;
        end else if (w_timeout) begin
          abort_pulse = 1'b1;
          w_release   = 1'b1;
          w_next      = ST_ARB;
        end
      end
      ST_ISSUE: begin
        uart_tx_en = 1'b1;
        w_next     = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: if (uart_tx_busy) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (!uart_tx_busy) begin
          if (r_last) begin
            w_release = 1'b1;
            w_next    = ST_ARB;
          end else begin
            w_next = ST_ACCEPT;
          end
        end
      end
      default: w_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ARB;
      r_grant   <= '0;
      r_rr      <= '0;
      r_active  <= 1'b0;
      r_last    <= 1'b0;
      r_hold    <= '0;
      r_tx_data <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      // The tag is preloaded on grant; untagged builds overwrite it in ACCEPT before any ISSUE.
      if (r_state == ST_ARB && w_found) begin
        r_grant  <= w_pick;
        r_active <= 1'b1;
        r_hold   <= TAG_BASE | 8'(w_pick);
        r_last   <= 1'b0;
      end
      if (w_accept) begin
        r_hold <= w_bytes[r_grant];
        r_last <= req_last[r_grant];
      end
      if (r_state == ST_ISSUE) r_tx_data <= r_hold;
      if (w_accept || w_release)      r_cnt <= '0;
      else if (r_state == ST_ACCEPT)  r_cnt <= r_cnt + 1'b1;
      if (w_release) begin
        r_active <= 1'b0;
        r_rr     <= (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;
      end
    end
  end

  a_no_issue_while_busy: assert property (
    @(posedge clk) disable iff (rst) (r_state == ST_ISSUE) |-> !uart_tx_busy);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of arbitration scenarios plus timeout/reset sequences.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 50;
`ifdef UART_ARB_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_en;
  logic           uart_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           grant_active;
  logic           abort_pulse;

  uart_tx_arbiter #(.N_REQ(N), .IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_en(uart_tx_en), .uart_tx_busy(uart_busy),
    .grant_id(grant_id), .grant_active(grant_active), .abort_pulse(abort_pulse)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [8:0] rbuf [N][16];
  int rhead [N];
  int rtail [N];
  logic [N-1:0] hs = '0;
  int acc_q [$];
  logic [7:0] wire_q [$];
  int rdy_cycles [N];
  int idle_cnt = 0, abort_seen = 0, abort_at = 0, onehot_err = 0, busy_issue = 0;
  logic [1:0] abort_gid = '0;
  logic en_seen = 1'b0;
  int fcnt = 0;

  // Requester side: retire last cycle's handshakes, present queue heads, then sample.
  always begin
    @(negedge clk);
    for (int i = 0; i < N; i++) if (hs[i]) begin rhead[i]++; acc_q.push_back(i); end
    for (int i = 0; i < N; i++) begin
      if (rhead[i] < rtail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*8 +: 8] = rbuf[i][rhead[i]][7:0];
        req_last[i] = rbuf[i][rhead[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i] = 1'b0;
      end
    end
    #1;
    hs = req_valid & req_ready;
    for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cycles[i]++;
    if (req_ready[2] && !req_valid[2]) idle_cnt++;
    if (abort_pulse) begin abort_seen++; abort_at = idle_cnt; abort_gid = grant_id; end
    if ($countones(req_ready) > 1 || (req_ready != '0 && !grant_active)) onehot_err++;
  end

  // UART model: busy rises on the edge that samples tx_en and stays up 4 cycles.
  always @(negedge clk or posedge rst) begin
    if (rst) en_seen = 1'b0;
    else begin
      en_seen = uart_tx_en;
      if (uart_tx_en) begin
        wire_q.push_back(uart_tx_data);
        if (uart_busy) busy_issue++;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin uart_busy <= 1'b0; fcnt <= 0; end
    else if (en_seen) begin uart_busy <= 1'b1; fcnt <= 4; end
    else if (fcnt > 0) begin
      fcnt <= fcnt - 1;
      if (fcnt == 1) uart_busy <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic l);
    rbuf[r][rtail[r]] = {l, d};
    rtail[r]++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; rdy_cycles[i] = 0; end
    wire_q.delete();
    acc_q.delete();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      @(negedge clk); #3; n++;
      done = !grant_active && (hs == '0);
      for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) done = 1'b0;
    end
    tests++;
    if (!done) begin fails++; $display("FAIL %s idle: got busy after %0d cycles, want idle", nm, n); end
  endtask

  task automatic wait_wire(input string nm, input int cnt);
    int n;
    n = 0;
    while (wire_q.size() < cnt && n < 500) begin @(negedge clk); #3; n++; end
    chk({nm, " wire wait"}, 32'(wire_q.size() >= cnt), 32'd1);
  endtask

  task automatic cmp_wire(input string nm, input logic [7:0] exp [$]);
    chk({nm, " wire count"}, 32'(wire_q.size()), 32'(exp.size()));
    for (int j = 0; j < exp.size(); j++)
      chk($sformatf("%s wire[%0d]", nm, j), (j < wire_q.size()) ? 32'(wire_q[j]) : 32'hDEAD, 32'(exp[j]));
  endtask

  task automatic cmp_order(input string nm, input int exp [$]);
    chk({nm, " accept count"}, 32'(acc_q.size()), 32'(exp.size()));
    for (int j = 0; j < exp.size(); j++)
      chk($sformatf("%s grant[%0d]", nm, j), (j < acc_q.size()) ? 32'(acc_q[j]) : 32'hDEAD, 32'(exp[j]));
  endtask

  function automatic logic [7:0] tagb(input int r);
    return 8'hA0 | 8'(r);
  endfunction

  typedef struct {
    logic [3:0] mask;
    int         len;
    int         npkt;
    int         n_exp;
    int         order [8];
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ew [$];
    int eo [$];
    int c [N];

    // Expected grant orders are derived by hand from the carried-over rr pointer.
    tbl[0] = '{4'b1010, 2, 1, 4, '{1, 1, 3, 3, 0, 0, 0, 0}};
    tbl[1] = '{4'b1111, 1, 2, 8, '{0, 1, 2, 3, 0, 1, 2, 3}};
    tbl[2] = '{4'b0101, 3, 1, 6, '{0, 0, 0, 2, 2, 2, 0, 0}};
    tbl[3] = '{4'b1001, 1, 1, 2, '{3, 0, 0, 0, 0, 0, 0, 0}};
    tbl[4] = '{4'b0110, 1, 2, 4, '{1, 2, 1, 2, 0, 0, 0, 0}};
    tbl[5] = '{4'b1100, 2, 1, 4, '{3, 3, 2, 2, 0, 0, 0, 0}};

    clear_all();
    repeat (3) @(negedge clk);
    #3;
    chk("rst tx_en", 32'(uart_tx_en), 0);
    chk("rst grant_active", 32'(grant_active), 0);
    chk("rst grant_id", 32'(grant_id), 0);
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst tx_data", 32'(uart_tx_data), 0);
    chk("rst abort", 32'(abort_pulse), 0);
    rst = 1'b0;

    // Single requester, two-byte packet.
    clear_all();
    push_byte(0, 8'h55, 1'b0);
    push_byte(0, 8'h0F, 1'b1);
    wait_idle("single");
    ew.delete(); if (TAG_ON) ew.push_back(tagb(0)); ew.push_back(8'h55); ew.push_back(8'h0F);
    cmp_wire("single", ew);
    eo.delete(); eo.push_back(0); eo.push_back(0);
    cmp_order("single", eo);
    chk("single ready cycles", 32'(rdy_cycles[0]), 2);
    chk("single grant released", 32'(grant_active), 0);
    chk("single tx_data hold", 32'(uart_tx_data), 32'h0F);

    for (int e = 0; e < 6; e++) begin
      clear_all();
      for (int i = 0; i < N; i++) begin
        c[i] = 0;
        if (tbl[e].mask[i])
          for (int p = 0; p < tbl[e].npkt; p++)
            for (int k = 0; k < tbl[e].len; k++)
              push_byte(i, 8'(i*16 + p*tbl[e].len + k), k == tbl[e].len - 1);
      end
      wait_idle($sformatf("vec%0d", e));
      ew.delete(); eo.delete();
      for (int j = 0; j < tbl[e].n_exp; j++) begin
        int r;
        r = tbl[e].order[j];
        eo.push_back(r);
        if (TAG_ON && (c[r] % tbl[e].len) == 0) ew.push_back(tagb(r));
        ew.push_back(8'(r*16 + c[r]));
        c[r]++;
      end
      cmp_order($sformatf("vec%0d", e), eo);
      cmp_wire($sformatf("vec%0d", e), ew);
    end

    // Inactivity timeout: req 2 stalls mid-packet while req 0 waits.
    clear_all();
    idle_cnt = 0;
    abort_seen = 0;
    push_byte(2, 8'h2A, 1'b0);
    wait_wire("timeout", TAG_ON ? 2 : 1);
    push_byte(0, 8'h05, 1'b1);
    wait_idle("timeout");
    chk("timeout abort count", 32'(abort_seen), 1);
    chk("timeout abort cycle", 32'(abort_at), TO);
    chk("timeout abort grant", 32'(abort_gid), 2);
    eo.delete(); eo.push_back(2); eo.push_back(0);
    cmp_order("timeout", eo);
    ew.delete();
    if (TAG_ON) ew.push_back(tagb(2));
    ew.push_back(8'h2A);
    if (TAG_ON) ew.push_back(tagb(0));
    ew.push_back(8'h05);
    cmp_wire("timeout", ew);

    // Reset while a frame is in flight, then a clean packet.
    clear_all();
    push_byte(0, 8'h77, 1'b0);
    push_byte(0, 8'h78, 1'b1);
    wait_wire("reset", 1);
    repeat (2) @(negedge clk);
    #3;
    chk("reset locked before", 32'(grant_active), 1);
    chk("reset uart busy before", 32'(uart_busy), 1);
    rst = 1'b1;
    #1;
    chk("reset tx_en", 32'(uart_tx_en), 0);
    chk("reset grant_active", 32'(grant_active), 0);
    chk("reset grant_id", 32'(grant_id), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset tx_data", 32'(uart_tx_data), 0);
    repeat (2) @(negedge clk);
    #3;
    clear_all();
    rst = 1'b0;
    push_byte(0, 8'h61, 1'b0);
    push_byte(0, 8'h62, 1'b1);
    wait_idle("post-reset");
    ew.delete(); if (TAG_ON) ew.push_back(tagb(0)); ew.push_back(8'h61); ew.push_back(8'h62);
    cmp_wire("post-reset", ew);
    eo.delete(); eo.push_back(0); eo.push_back(0);
    cmp_order("post-reset", eo);

    chk("ready one-hot to owner", 32'(onehot_err), 0);
    chk("issue while busy", 32'(busy_issue), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between N_REQ byte-stream requesters. Round-robin arbitration with packet lock: a granted requester keeps the UART until it sends a byte flagged last, or until an inactivity timeout aborts its packet. Sits between the UART's tx_data/tx_en/tx_busy port and the on-chip clients: debug console, status reporter and loopback.

Parameters:
N_REQ, 4, number of requesters (2..8)
IDLE_TIMEOUT, 1000, clk cycles a locked requester may hold req_valid low before forced release; 0 disables the timeout
TAG_BASE, 8'hA0, tag byte base; tag = TAG_BASE | grant_id (used only with UART_ARB_TAG_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester byte valid
req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  N_REQ  byte closes the packet
req_ready  out  N_REQ  byte accepted this cycle when valid&ready
uart_tx_data  out  8  byte to UART
uart_tx_en  out  1  single-cycle send strobe to UART
uart_tx_busy  in  1  UART transmitter busy; rises the cycle after tx_en is sampled, falls after the stop bit
grant_id  out  clog2(N_REQ)  current owner
grant_active  out  1  a requester holds the lock
abort_pulse  out  1  one-cycle pulse on timeout release

Behaviour:
- Reset (async, rst=1): state=ARB, rr_ptr=0, all outputs 0, hold register 0, timeout counter 0. Reset mid-byte drops uart_tx_en immediately; the UART's own reset recovers the line.
- States: ARB, TAG, ACCEPT, ISSUE, WAIT_BUSY, WAIT_DONE.
- ARB:
  - Select first i with req_valid[i], searching from rr_ptr upward with wrap.
  - If a requester is found: register grant_id, grant_active=1, go to ACCEPT (TAG when the macro is defined).
  - If none: stay in ARB.
- ACCEPT:
  - req_ready[grant_id]=1 combinationally; every other ready bit is 0.
  - On valid: latch data into hold, latch last into last_q, clear the timeout counter, go to ISSUE.
  - Otherwise increment the timeout counter.
  - When the counter reaches IDLE_TIMEOUT (nonzero): abort_pulse=1, release.
- ISSUE: uart_tx_en=1 for exactly one cycle, uart_tx_data=hold; go to WAIT_BUSY.
- WAIT_BUSY: stay until uart_tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until uart_tx_busy=0, then:
  - tag just sent: go to ACCEPT.
  - last_q=1: release.
  - otherwise: go to ACCEPT.
- Release: grant_active=0, rr_ptr = grant_id+1 mod N_REQ, go to ARB. A released requester is granted again only after all other valid requesters have been served once.
- uart_tx_data holds its value outside ISSUE.
- Only the granted requester is ever readied. A non-granted req_valid is ignored until arbitration.
- Simultaneous events:
  - Timeout and valid in the same cycle: the valid wins and the byte is accepted.
  - uart_tx_busy already 1 on entry to ISSUE: illegal. Guarded by an assertion only; the block never issues while busy.
- Per-byte overhead beyond UART frame time: 3 cycles (ACCEPT, ISSUE, WAIT_BUSY). The ARB→first-byte cost is 1 additional cycle.

Optional Feature:
UART_ARB_TAG_EN
- Defined: ARB goes to TAG, which loads hold=TAG_BASE|grant_id and runs ISSUE/WAIT_BUSY/WAIT_DONE before the first ACCEPT. Each packet on the wire is prefixed by one tag byte. A timeout after the tag is sent still emits only the tag.
- Undefined: no TAG state; packets are sent untagged.

Decomposition:
- Package uart_arb_pkg: state encoding (6 states, 3-bit), TAG_BASE default, requester-count limit constant.
- Sub-module uart_rr_pick: combinational rotating priority encoder (req vector, rr_ptr → grant index, found flag). It is the only natural split.

Test Plan:
- Single requester 0 sends 0x55,0x0F(last) → wire carries 0x55 then 0x0F; req_ready pulses exactly twice; grant_active falls after second frame; rr_ptr=1.
- Req 1 and 3 valid together with rr_ptr=0 → req 1 packet wholly sent first (no interleaving of 3's bytes), then req 3; grant_id 1→3.
- Req 2 sends one non-last byte then drops valid; IDLE_TIMEOUT=50 → abort_pulse on the 50th idle cycle; grant moves to next valid requester; no extra tx_en.
- All 4 requesters continuously valid with 1-byte packets → grant order 0,1,2,3,0; no requester starved.
- rst asserted during WAIT_DONE → outputs 0 in same cycle; after release, a new packet from req 0 completes normally.
- With UART_ARB_TAG_EN, req 2 sends 0x41(last) → wire shows 0xA2 then 0x41.
